// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - decode/writeback bundle for the multi-port register file
//
// Purpose: groups the read, write and reserve signals of reg_file_mp.
// Signals:
//   rs_1, rs_2               read addresses (decode -> regfile)
//   rs_1_data, rs_2_data     read data (regfile -> decode)
//   rs_1_busy, rs_2_busy     scoreboard bits of the read addresses
//   reg_wrt_en, rd, rd_data  write port A (ALU writeback)
//   reg_wrt_en_b, rd_b,
//   rd_b_data                write port B (load writeback)
//   rsv_en, rsv_rd           reserve a destination at issue
// Modports: master = datapath side, slave = register file.

interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_1;
  logic [ADDR_W-1:0] rs_2;
  logic [DATA_W-1:0] rs_1_data;
  logic [DATA_W-1:0] rs_2_data;
  logic              rs_1_busy;
  logic              rs_2_busy;
  logic              reg_wrt_en;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] rd_data;
  logic              reg_wrt_en_b;
  logic [ADDR_W-1:0] rd_b;
  logic [DATA_W-1:0] rd_b_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_rd;

  modport master (
    output rs_1, rs_2, reg_wrt_en, rd, rd_data, reg_wrt_en_b, rd_b, rd_b_data,
           rsv_en, rsv_rd,
    input  rs_1_data, rs_2_data, rs_1_busy, rs_2_busy
  );

  modport slave (
    input  rs_1, rs_2, reg_wrt_en, rd, rd_data, reg_wrt_en_b, rd_b, rd_b_data,
           rsv_en, rsv_rd,
    output rs_1_data, rs_2_data, rs_1_busy, rs_2_busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - 2-read/2-write register file with busy scoreboard
//
// Purpose: parametrised register file with optional hardwired x0, optional
// write-to-read bypass and a per-register busy scoreboard.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous reset, active low; clears data and busy bits
//   io_rf    reg_file_mp_if.slave bundle (reads, writes A/B, reserve)

module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  reg_file_mp_if.slave  io_rf
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic              w_wr_a;
  logic              w_wr_b;
  logic              w_rsv;
  logic [DATA_W-1:0] w_rs_1_data;
  logic [DATA_W-1:0] w_rs_2_data;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // Writes and reserves aimed at a hardwired x0 are dropped here, so x0 never
  // stores data and never becomes busy.
  assign w_wr_a = io_rf.reg_wrt_en   && !is_zero_reg(io_rf.rd);
  assign w_wr_b = io_rf.reg_wrt_en_b && !is_zero_reg(io_rf.rd_b);
  assign w_rsv  = io_rf.rsv_en       && !is_zero_reg(io_rf.rsv_rd);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      // Port B is assigned last so it wins an rd == rd_b collision.
      if (w_wr_a) r_regs[io_rf.rd]   <= io_rf.rd_data;
      if (w_wr_b) r_regs[io_rf.rd_b] <= io_rf.rd_b_data;
      // Writeback releases, then a same-cycle reserve re-marks: the new
      // producer issued this cycle still owns the register.
      if (w_wr_a) r_busy[io_rf.rd]     <= 1'b0;
      if (w_wr_b) r_busy[io_rf.rd_b]   <= 1'b0;
      if (w_rsv)  r_busy[io_rf.rsv_rd] <= 1'b1;
    end
  end

  always_comb begin
    w_rs_1_data = r_regs[io_rf.rs_1];
    if (BYPASS) begin
      if (w_wr_a && (io_rf.rd == io_rf.rs_1))   w_rs_1_data = io_rf.rd_data;
      if (w_wr_b && (io_rf.rd_b == io_rf.rs_1)) w_rs_1_data = io_rf.rd_b_data;
    end
    if (is_zero_reg(io_rf.rs_1)) w_rs_1_data = '0;
  end

  always_comb begin
    w_rs_2_data = r_regs[io_rf.rs_2];
    if (BYPASS) begin
      if (w_wr_a && (io_rf.rd == io_rf.rs_2))   w_rs_2_data = io_rf.rd_data;
      if (w_wr_b && (io_rf.rd_b == io_rf.rs_2)) w_rs_2_data = io_rf.rd_b_data;
    end
    if (is_zero_reg(io_rf.rs_2)) w_rs_2_data = '0;
  end

  assign io_rf.rs_1_data = w_rs_1_data;
  assign io_rf.rs_2_data = w_rs_2_data;
  // Busy is reported from stored state only; same-cycle reserve/release is
  // visible after the edge.
  assign io_rf.rs_1_busy = r_busy[io_rf.rs_1];
  assign io_rf.rs_2_busy = r_busy[io_rf.rs_2];

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp

module tb_reg_file_mp;

  logic clk;
  logic rst_n;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) rf ();

  reg_file_mp #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_rf   (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_reg  [32];
  bit          m_busy [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural view of a read: x0 is zero, otherwise the newest value
  // being written this cycle (load port beats ALU port), else stored data.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (rf.reg_wrt_en_b && rf.rd_b == a) return rf.rd_b_data;
    if (rf.reg_wrt_en && rf.rd == a) return rf.rd_data;
    return m_reg[a];
  endfunction

  task automatic model_check();
    check("rs1_data", rf.rs_1_data, exp_read(rf.rs_1));
    check("rs2_data", rf.rs_2_data, exp_read(rf.rs_2));
    check("rs1_busy", {31'b0, rf.rs_1_busy}, {31'b0, m_busy[rf.rs_1]});
    check("rs2_busy", {31'b0, rf.rs_2_busy}, {31'b0, m_busy[rf.rs_2]});
  endtask

  task automatic model_update();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (rf.reg_wrt_en && rf.rd != 5'd0) m_reg[rf.rd] = rf.rd_data;
      if (rf.reg_wrt_en_b && rf.rd_b != 5'd0) m_reg[rf.rd_b] = rf.rd_b_data;
      if (rf.reg_wrt_en) m_busy[rf.rd] = 1'b0;
      if (rf.reg_wrt_en_b) m_busy[rf.rd_b] = 1'b0;
      if (rf.rsv_en && rf.rsv_rd != 5'd0) m_busy[rf.rsv_rd] = 1'b1;
    end
  endtask

  task automatic idle();
    rst_n           = 1'b1;
    rf.rs_1         = 5'd0;
    rf.rs_2         = 5'd0;
    rf.reg_wrt_en   = 1'b0;
    rf.rd           = 5'd0;
    rf.rd_data      = 32'h0;
    rf.reg_wrt_en_b = 1'b0;
    rf.rd_b         = 5'd0;
    rf.rd_b_data    = 32'h0;
    rf.rsv_en       = 1'b0;
    rf.rsv_rd       = 5'd0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Called at the negedge: check against the model, take the edge, update.
  task automatic tick();
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    settle();
    @(posedge clk);
    model_update();
    #1;
    rst_n = 1'b1;

    // Reset state of every address
    for (int a = 0; a < 32; a++) begin
      rf.rs_1 = 5'(a);
      rf.rs_2 = 5'(31 - a);
      settle();
      check("rst_data", rf.rs_1_data, 32'h0);
      check("rst_busy", {31'b0, rf.rs_2_busy}, 32'h0);
    end
    @(posedge clk);
    #1;

    // Write/readback with same-cycle bypass
    idle();
    rf.reg_wrt_en = 1'b1; rf.rd = 5'd2; rf.rd_data = 32'h400000CF; rf.rs_1 = 5'd2;
    settle();
    check("byp_r2", rf.rs_1_data, 32'h400000CF);
    tick();
    idle(); rf.rs_2 = 5'd2;
    settle();
    check("rd_r2", rf.rs_2_data, 32'h400000CF);
    tick();

    // Hardwired zero register
    idle();
    rf.reg_wrt_en = 1'b1; rf.rd = 5'd0; rf.rd_data = 32'h400000CD;
    rf.rsv_en = 1'b1; rf.rsv_rd = 5'd0; rf.rs_1 = 5'd0;
    settle();
    check("zero_byp", rf.rs_1_data, 32'h0);
    tick();
    idle();
    settle();
    check("zero_data", rf.rs_1_data, 32'h0);
    check("zero_busy", {31'b0, rf.rs_1_busy}, 32'h0);
    tick();

    // Write-port collision on r5
    idle();
    rf.reg_wrt_en = 1'b1; rf.rd = 5'd5; rf.rd_data = 32'h11;
    rf.reg_wrt_en_b = 1'b1; rf.rd_b = 5'd5; rf.rd_b_data = 32'h22;
    rf.rs_1 = 5'd5; rf.rs_2 = 5'd5;
    settle();
    check("coll_byp", rf.rs_2_data, 32'h22);
    tick();
    idle(); rf.rs_1 = 5'd5;
    settle();
    check("coll_rd", rf.rs_1_data, 32'h22);
    tick();

    // Scoreboard on r7
    idle(); rf.rsv_en = 1'b1; rf.rsv_rd = 5'd7; rf.rs_1 = 5'd7;
    settle();
    check("sb_no_byp", {31'b0, rf.rs_1_busy}, 32'h0);
    tick();
    idle(); rf.rs_1 = 5'd7;
    rf.reg_wrt_en = 1'b1; rf.rd = 5'd7; rf.rd_data = 32'h66;
    rf.rsv_en = 1'b1; rf.rsv_rd = 5'd7;
    settle();
    check("sb_rsv", {31'b0, rf.rs_1_busy}, 32'h1);
    tick();
    idle(); rf.rs_1 = 5'd7;
    rf.reg_wrt_en = 1'b1; rf.rd = 5'd7; rf.rd_data = 32'h77;
    settle();
    check("sb_rsv_wins", {31'b0, rf.rs_1_busy}, 32'h1);
    tick();
    idle(); rf.rs_1 = 5'd7;
    settle();
    check("sb_release", {31'b0, rf.rs_1_busy}, 32'h0);
    check("sb_data", rf.rs_1_data, 32'h77);
    tick();

    // Reset in the middle of a write and reserve
    idle();
    rf.reg_wrt_en = 1'b1; rf.rd = 5'd3; rf.rd_data = 32'h55;
    rf.rsv_en = 1'b1; rf.rsv_rd = 5'd4;
    settle();
    tick();
    idle();
    rf.reg_wrt_en = 1'b1; rf.rd = 5'd3; rf.rd_data = 32'hAA;
    rf.rsv_en = 1'b1; rf.rsv_rd = 5'd4;
    rf.rs_1 = 5'd3; rf.rs_2 = 5'd4; rst_n = 1'b0;
    settle();
    check("pre_rst_busy", {31'b0, rf.rs_2_busy}, 32'h1);
    tick();
    idle(); rf.rs_1 = 5'd3; rf.rs_2 = 5'd4;
    settle();
    check("mid_rst_data", rf.rs_1_data, 32'h0);
    check("mid_rst_busy", {31'b0, rf.rs_2_busy}, 32'h0);
    tick();

    // Randomized traffic against the model
    repeat (600) begin
      rst_n           = ($urandom_range(0, 49) != 0);
      rf.rs_1         = rnd_addr();
      rf.rs_2         = rnd_addr();
      rf.reg_wrt_en   = 1'($urandom_range(0, 1));
      rf.rd           = rnd_addr();
      rf.rd_data      = $urandom;
      rf.reg_wrt_en_b = 1'($urandom_range(0, 1));
      rf.rd_b         = rnd_addr();
      rf.rd_b_data    = $urandom;
      rf.rsv_en       = 1'($urandom_range(0, 1));
      rf.rsv_rd       = rnd_addr();
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
